// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier and its result reader:
// default dimensions, FSM state encodings and an index-width helper.
package matrix_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_M          = 8;
  localparam int DEF_N          = 8;
  localparam int DEF_P          = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_reader.sv
// Captures a packed result matrix on done and streams it element by element over a
// valid/ready port. Define MATRIX_READER_COLMAJOR_EN for column-major order (default row-major).
module matrix_result_reader
  import matrix_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  M          = DEF_M,
  parameter int  P          = DEF_P,
  localparam int RW         = idx_w(M),
  localparam int CW         = idx_w(P)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done,
  input  logic [M*P*DATA_WIDTH-1:0] result_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [RW-1:0]             out_row,
  output logic [CW-1:0]             out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int          OW      = idx_w(M*P*DATA_WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(M-1);
  localparam logic [CW-1:0] COL_MAX = CW'(P-1);
  localparam logic        SINGLE  = (M == 1) && (P == 1);

  state_e                      state_q;
  logic                        valid_q, busy_q, last_q, overrun_q;
  logic [DATA_WIDTH-1:0]       data_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [M*P*DATA_WIDTH-1:0]   buf_q;

  logic                        xfer, final_xfer, cap;
  logic [RW-1:0]               row_nx;
  logic [CW-1:0]               col_nx;
  logic                        last_nx;
  logic [OW-1:0]               off_nx;
  logic [DATA_WIDTH-1:0]       elem_nx;

  always_comb begin
    xfer       = valid_q && out_ready;
    final_xfer = xfer && last_q;
    // A done is only accepted when the buffer is free or being freed this edge.
    cap        = done && ((state_q == IDLE) || final_xfer);
    row_nx     = row_q;
    col_nx     = col_q;
`ifdef MATRIX_READER_COLMAJOR_EN
    if (row_q == ROW_MAX) begin
      row_nx = '0;
      col_nx = col_q + 1'b1;
    end else begin
      row_nx = row_q + 1'b1;
    end
`else
    if (col_q == COL_MAX) begin
      col_nx = '0;
      row_nx = row_q + 1'b1;
    end else begin
      col_nx = col_q + 1'b1;
    end
`endif
    last_nx = (row_nx == ROW_MAX) && (col_nx == COL_MAX);
    off_nx  = OW'((int'(row_nx) * P + int'(col_nx)) * DATA_WIDTH);
    elem_nx = buf_q[off_nx +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (cap) buf_q <= result_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      if (cap) begin
        state_q <= STREAM;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        last_q  <= SINGLE;
        data_q  <= result_c[DATA_WIDTH-1:0];
        row_q   <= '0;
        col_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          STREAM: begin
            if (done) overrun_q <= 1'b1;
            if (final_xfer) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
            end else if (xfer) begin
              data_q <= elem_nx;
              row_q  <= row_nx;
              col_q  <= col_nx;
              last_q <= last_nx;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed bench for matrix_result_reader at default 8x8x8 dimensions; expected
// element order follows MATRIX_READER_COLMAJOR_EN when defined.
module tb_matrix_result_reader;

  localparam int DW = 8;
  localparam int M  = 8;
  localparam int P  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done = 1'b0;
  logic [M*P*DW-1:0] result_c = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int failures = 0;

  matrix_result_reader #(.DATA_WIDTH(DW), .M(M), .P(P)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .result_c(result_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Buffer index of the n-th streamed element.
  function automatic int order_k(input int n);
`ifdef MATRIX_READER_COLMAJOR_EN
    return (n % M) * P + (n / M);
`else
    return n;
`endif
  endfunction

  task automatic load(input int base);
    for (int k = 0; k < M*P; k++) result_c[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic check_elem(input int base, input int n);
    int k;
    k = order_k(n);
    chk($sformatf("valid[%0d]", n), 64'(out_valid), 64'(1));
    chk($sformatf("data[%0d]", n), 64'(out_data), 64'((base + k) & 8'hff));
    chk($sformatf("row[%0d]", n), 64'(out_row), 64'(k / P));
    chk($sformatf("col[%0d]", n), 64'(out_col), 64'(k % P));
    chk($sformatf("last[%0d]", n), 64'(out_last), 64'(n == M*P-1));
    chk($sformatf("busy[%0d]", n), 64'(busy), 64'(1));
  endtask

  task automatic stream(input int base, input int from, input int to);
    for (int n = from; n <= to; n++) begin
      check_elem(base, n);
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_last"}, 64'(out_last), 64'(0));
    chk({tag, "_row"}, 64'(out_row), 64'(0));
    chk({tag, "_col"}, 64'(out_col), 64'(0));
  endtask

  initial begin
    int n;
    int cyc;
    logic [3:0] pat;

    // Reset state
    #2;
    check_idle("rst");
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_idle("idle_ready");

    // Full stream with ready held high
    load(0);
    pulse_done();
    stream(0, 0, M*P-1);
    check_idle("t1_end");
    chk("t1_overrun", 64'(overrun), 64'(0));

    // Ready pattern 1,0,0,1: stalls must hold the current element
    pat = 4'b1001;
    pulse_done();
    n = 0;
    cyc = 0;
    while (n < M*P && cyc < 400) begin
      out_ready = pat[cyc % 4];
      check_elem(0, n);
      step();
      if (out_ready) n++;
      cyc++;
    end
    chk("t2_count", 64'(n), 64'(M*P));
    out_ready = 1'b1;
    step();
    check_idle("t2_end");

    // Done while streaming is dropped and flags overrun
    load(0);
    pulse_done();
    stream(0, 0, 9);
    check_elem(0, 10);
    load(100);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t3_overrun_set", 64'(overrun), 64'(1));
    stream(0, 11, M*P-1);
    check_idle("t3_end");
    chk("t3_overrun_sticky", 64'(overrun), 64'(1));

    // Asynchronous reset mid-stream, then restart from element 0
    load(0);
    pulse_done();
    stream(0, 0, 19);
    check_elem(0, 20);
    rst_n = 1'b0;
    #1;
    check_idle("t5_rst");
    chk("t5_rst_data", 64'(out_data), 64'(0));
    chk("t5_rst_overrun", 64'(overrun), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    pulse_done();
    stream(0, 0, M*P-1);
    check_idle("t5_end");

    // Back-to-back: new done on the final-transfer edge
    load(0);
    pulse_done();
    stream(0, 0, M*P-2);
    check_elem(0, M*P-1);
    load(100);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t4_data0", 64'(out_data), 64'(100));
    chk("t4_valid", 64'(out_valid), 64'(1));
    chk("t4_overrun", 64'(overrun), 64'(0));
    stream(100, 0, M*P-1);
    check_idle("t4_end");
    chk("t4_overrun_end", 64'(overrun), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_result_reader.md
MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one result element.
REQ-002 SHALL have parameter M, default 8, rows of result matrix C.
REQ-003 SHALL have parameter P, default 8, columns of result matrix C.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port done  input  1  one-cycle pulse from the multiplier; result_c valid in that cycle.
REQ-007 SHALL have port result_c  input  M*P*DATA_WIDTH  packed result; element (r,c) at bits [((r*P+c)*DATA_WIDTH) +: DATA_WIDTH].
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-009 SHALL have port out_ready  input  1  downstream accepts element.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  current element.
REQ-011 SHALL have port out_row  output  max(1,ceil(log2 M))  row index of out_data.
REQ-012 SHALL have port out_col  output  max(1,ceil(log2 P))  column index of out_data.
REQ-013 SHALL have port out_last  output  1  out_data is final element of the matrix.
REQ-014 SHALL have port busy  output  1  a matrix is captured and not fully streamed.
REQ-015 SHALL have port overrun  output  1  sticky: done arrived while busy and was dropped.

Function
REQ-016 SHALL implement states IDLE and STREAM; IDLE->STREAM on done; STREAM->IDLE on transfer of final element.
REQ-017 SHALL, in IDLE with done=1 at edge T, copy result_c to an internal buffer and present element 0 with out_valid=1, busy=1 immediately after T (one-cycle latency).
REQ-018 SHALL define transfer as out_valid && out_ready at a rising edge; each transfer advances to the next element.
REQ-019 SHALL order elements row-major by default: col increments 0..P-1, then wraps to 0 and row increments; 0..M-1.
REQ-020 SHALL hold out_data, out_row, out_col, out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL assert out_last exactly when out_row=M-1 and out_col=P-1 (row-major) while out_valid=1.
REQ-022 SHALL, after final transfer with no done, drop out_valid, busy, out_last and zero out_row/out_col in the next cycle.
REQ-023 SHALL, on done coinciding with final transfer, capture the new result_c, remain in STREAM, and present new element 0 next cycle (zero-gap back-to-back); overrun not set.
REQ-024 SHALL, on done in STREAM without final transfer, ignore result_c, leave the buffer untouched, and set overrun.
REQ-025 SHALL pass elements unmodified; no sign extension or arithmetic on data.
REQ-026 SHALL keep out_valid=0 in IDLE regardless of out_ready.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0, asynchronously.
REQ-028 SHALL abandon any in-progress stream on reset; buffer contents need not be cleared.
REQ-029 SHALL clear overrun only by reset.

Configuration
REQ-030 SHALL, with MATRIX_READER_COLMAJOR_EN defined, order elements column-major: row increments 0..M-1, then wraps and col increments; out_last at (M-1,P-1) still; without it, row-major per REQ-019. Ports unchanged in both builds.

Structure
REQ-031 SHALL take DATA_WIDTH, M, N, P defaults and the IDLE/STREAM state encodings from shared package matrix_pkg, common with the multiplier.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Defaults, result_c element k = k, out_ready=1 -> 64 consecutive transfers, data 0..63, out_last only on data 63 (row 7, col 7), busy low after.
REQ-034 out_ready toggling 1,0,0,1 -> no element lost or duplicated; out_data held at same value during ready=0 cycles.
REQ-035 done pulsed again at element 10 -> overrun=1, stream continues with original data 11..63.
REQ-036 Second done on the final-transfer edge with element k = 100+k -> next cycle out_data=100, out_valid stays 1, overrun=0.
REQ-037 rst_n low at element 20 -> all outputs 0 immediately; next done restarts at element 0.
REQ-038 MATRIX_READER_COLMAJOR_EN, element k = k -> order 0,8,16,...,56,1,9,...,63; out_last on 63.
